// File: rtl/msg_defs_pkg.sv
// Shared message definitions for the serial link: start markers, flag codes,
// CRC parameters and the transmit framer state encoding.
package msg_defs;

    localparam logic [7:0]  MARKER_MASTER  = 8'hA5;
    localparam logic [7:0]  MARKER_SLAVE   = 8'h5A;

    localparam logic [7:0]  FLAG_READ      = 8'h01;
    localparam logic [7:0]  FLAG_WRITE     = 8'h02;
    localparam logic [7:0]  FLAG_ACK       = 8'h04;
    localparam logic [7:0]  FLAG_ERR_REPLY = 8'h80;

    localparam logic [15:0] CRC_POLY       = 16'h1021;
    localparam logic [15:0] CRC_INIT       = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MRK,
        ST_FLG,
        ST_ADR,
        ST_LEN,
        ST_PAY,
        ST_CRCH,
        ST_CRCL
    } tx_state_e;

endpackage

// File: rtl/tx_frame_build_crc.sv
// CRC-16 (poly CRC_POLY, MSB-first, unreflected) advanced by one data byte.
// Purely combinational so the receive side can reuse it unchanged.
module crc16_byte
    import msg_defs::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  d,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Fold the byte into the high half, then shift out eight bits
    always_comb begin
        c = crc_in ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/tx_frame_build.sv
// Transmit framer: MARKER_SLAVE, flag, addr, N, N payload bytes, CRC high,
// CRC low, over a valid/ready byte interface with a show-ahead payload source.
// Optional feature macro TX_ERR_REPLY_EN: adds rx_errs/rx_frame_end and sends
// an autonomous one-byte error-reply frame after a received frame ends.
module tx_frame_build
    import msg_defs::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] flag,
    input  logic [7:0] addr,
    input  logic [7:0] len,
    input  logic [7:0] pl_data,
    output logic       pl_rd,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
`ifdef TX_ERR_REPLY_EN
    ,
    input  logic [5:0] rx_errs,
    input  logic       rx_frame_end
`endif
);

    tx_state_e   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  flag_q, flag_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;

    logic        accept;
    logic [15:0] crc_upd;
    logic [7:0]  pay_byte;
    logic        pay_from_src;

`ifdef TX_ERR_REPLY_EN
    logic        pend_q, pend_d;
    logic [5:0]  errs_q, errs_d;
    logic        reply_q, reply_d;
    logic [7:0]  rpl_byte_q, rpl_byte_d;
`endif

    assign accept   = tx_valid_q & tx_ready;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // The byte currently on tx_data is the one folded into the CRC on accept
    crc16_byte u_crc (
        .crc_in  (crc_q),
        .d       (tx_data_q),
        .crc_out (crc_upd)
    );

    // Next-state, next-byte and pl_rd strobe; each non-idle state waits for accept
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        flag_d     = flag_q;
        addr_d     = addr_q;
        len_d      = len_q;
        pl_rd      = 1'b0;
`ifdef TX_ERR_REPLY_EN
        pend_d       = pend_q;
        errs_d       = errs_q;
        reply_d      = reply_q;
        rpl_byte_d   = rpl_byte_q;
        pay_byte     = reply_q ? rpl_byte_q : pl_data;
        pay_from_src = ~reply_q;
`else
        pay_byte     = pl_data;
        pay_from_src = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_MRK;
                    tx_data_d  = MARKER_SLAVE;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = 8'd0;
                    crc_d      = CRC_INIT;
                    flag_d     = flag;
                    addr_d     = addr;
                    len_d      = len;
`ifdef TX_ERR_REPLY_EN
                    reply_d    = 1'b0;
                end else if (pend_q) begin
                    state_d    = ST_MRK;
                    tx_data_d  = MARKER_SLAVE;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = 8'd0;
                    crc_d      = CRC_INIT;
                    flag_d     = FLAG_ERR_REPLY;
                    addr_d     = 8'h00;
                    len_d      = 8'd1;
                    reply_d    = 1'b1;
                    pend_d     = 1'b0;
                    rpl_byte_d = {2'b00, errs_q};
`endif
                end
            end
            ST_MRK: if (accept) begin
                crc_d     = crc_upd;
                tx_data_d = flag_q;
                state_d   = ST_FLG;
            end
            ST_FLG: if (accept) begin
                crc_d     = crc_upd;
                tx_data_d = addr_q;
                state_d   = ST_ADR;
            end
            ST_ADR: if (accept) begin
                crc_d     = crc_upd;
                tx_data_d = len_q;
                state_d   = ST_LEN;
            end
            ST_LEN: if (accept) begin
                crc_d = crc_upd;
                if (len_q != 8'd0) begin
                    tx_data_d = pay_byte;
                    pl_rd     = pay_from_src;
                    state_d   = ST_PAY;
                end else begin
                    tx_data_d = crc_upd[15:8];
                    state_d   = ST_CRCH;
                end
            end
            ST_PAY: if (accept) begin
                crc_d = crc_upd;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == len_q - 8'd1) begin
                    tx_data_d = crc_upd[15:8];
                    state_d   = ST_CRCH;
                end else begin
                    tx_data_d = pay_byte;
                    pl_rd     = pay_from_src;
                end
            end
            ST_CRCH: if (accept) begin
                tx_data_d = crc_q[7:0];
                state_d   = ST_CRCL;
            end
            ST_CRCL: if (accept) begin
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                crc_d      = CRC_INIT;
                state_d    = ST_IDLE;
`ifdef TX_ERR_REPLY_EN
                reply_d    = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef TX_ERR_REPLY_EN
        // A new clean frame end re-arms the reply even as an older one launches
        if (rx_frame_end && !rx_errs[0]) begin
            pend_d = 1'b1;
            errs_d = rx_errs;
        end
`endif
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 8'd0;
            crc_q      <= CRC_INIT;
`ifdef TX_ERR_REPLY_EN
            pend_q     <= 1'b0;
            errs_q     <= 6'd0;
            reply_q    <= 1'b0;
            rpl_byte_q <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
`ifdef TX_ERR_REPLY_EN
            pend_q     <= pend_d;
            errs_q     <= errs_d;
            reply_q    <= reply_d;
            rpl_byte_q <= rpl_byte_d;
`endif
        end
    end

    // Captured header fields are only read after a launch loads them
    always_ff @(posedge clk) begin
        flag_q <= flag_d;
        addr_q <= addr_d;
        len_q  <= len_d;
    end

endmodule

// File: tb/tb_tx_frame_build.sv
// Self-checking bench for tx_frame_build: a byte-queue frame model with a
// serial CRC drives one negedge compare process.
module tb_tx_frame_build;
    import msg_defs::*;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] flag = 8'h00;
    logic [7:0] addr = 8'h00;
    logic [7:0] len = 8'h00;
    logic [7:0] pl_data;
    logic       pl_rd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       done;
`ifdef TX_ERR_REPLY_EN
    logic [5:0] rx_errs = 6'd0;
    logic       rx_frame_end = 1'b0;
`endif

    tx_frame_build dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .flag     (flag),
        .addr     (addr),
        .len      (len),
        .pl_data  (pl_data),
        .pl_rd    (pl_rd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
`ifdef TX_ERR_REPLY_EN
        ,
        .rx_errs      (rx_errs),
        .rx_frame_end (rx_frame_end)
`endif
    );

    always #5 clk = ~clk;

    // Standalone CRC reference chain over ASCII "123456789"
    logic [9:0][15:0] chain;
    logic [8:0][7:0]  ascii;
    assign chain[0] = 16'hFFFF;
    for (genvar g = 0; g < 9; g++) begin : g_chain
        crc16_byte u_c (.crc_in(chain[g]), .d(ascii[g]), .crc_out(chain[g+1]));
    end

    // Payload source: show-ahead memory popped by pl_rd
    logic [7:0] pay_mem [0:1023];
    logic [9:0] rd_ptr = 10'd0;
    assign pl_data = pay_mem[rd_ptr];

    // Expected byte stream and per-frame expectations (written by stimulus only)
    logic [7:0] exp_mem [0:4095];
    int exp_wr = 0;
    int fr_bytes [0:63];
    int fr_pl    [0:63];
    int fr_lat   [0:63];
    int fr_wr = 0;
    bit rnd_mode = 1'b0;
    logic [7:0] pay_buf [0:255];

    // Compare-process state
    int checks = 0, errors = 0;
    int exp_rd = 0, done_idx = 0, cyc = 0, st_cyc = 0, fb = 0, fpl = 0, wd = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fbk;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fbk = r[15] ^ d[i];
            r = {r[14:0], 1'b0};
            if (fbk) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h expected none at cycle %0d", nm, act, cyc);
    endtask

    always @(posedge clk) begin
        #1;
        tx_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(posedge clk) begin
        bit rd_now;
        rd_now = pl_rd;
        #1;
        if (rd_now) rd_ptr = rd_ptr + 10'd1;
    end

    always @(negedge clk) begin
        logic [15:0] m;
        cyc++;
        if (cyc == 3) begin
            m = 16'hFFFF;
            for (int i = 0; i < 9; i++) m = crc_model(m, 8'h31 + 8'(i));
            chk("crc_model_123456789", {16'h0, m}, 32'h29B1);
            chk("crc16_byte_123456789", {16'h0, chain[9]}, 32'h29B1);
        end
        if (!n_rst) begin
            chk("rst_tx_valid", {31'h0, tx_valid}, 0);
            chk("rst_tx_data", {24'h0, tx_data}, 0);
            chk("rst_busy", {31'h0, busy}, 0);
            chk("rst_done", {31'h0, done}, 0);
            chk("rst_pl_rd", {31'h0, pl_rd}, 0);
            exp_rd = exp_wr; done_idx = fr_wr; fb = 0; fpl = 0; prev_stall = 1'b0; wd = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", {31'h0, tx_valid}, 1);
                chk("stall_hold_data", {24'h0, tx_data}, {24'h0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                if (exp_rd >= exp_wr) fail_now("extra_byte", {24'h0, tx_data});
                else begin
                    if (fb == 0) chk("marker_literal", {24'h0, tx_data}, 32'h5A);
                    chk("frame_byte", {24'h0, tx_data}, {24'h0, exp_mem[exp_rd]});
                    exp_rd++;
                end
                fb++;
            end
            if (pl_rd) fpl++;
            if (done) begin
                if (done_idx >= fr_wr) fail_now("unexpected_done", 1);
                else begin
                    chk("frame_len", fb, fr_bytes[done_idx]);
                    chk("frame_pl_rd", fpl, fr_pl[done_idx]);
                    chk("done_busy", {31'h0, busy}, 0);
                    chk("done_tx_valid", {31'h0, tx_valid}, 0);
                    if (fr_lat[done_idx] >= 0) chk("done_latency", cyc - st_cyc, fr_lat[done_idx]);
                    done_idx++;
                end
                fb = 0; fpl = 0;
            end
            if (start && !busy) st_cyc = cyc;
            if (done_idx == fr_wr && exp_rd == exp_wr) begin
                chk("idle_tx_valid", {31'h0, tx_valid}, 0);
                chk("idle_busy", {31'h0, busy}, 0);
            end
            if (done_idx != fr_wr) begin
                wd++;
                if (wd > 3000) begin
                    fail_now("frame_timeout", wd);
                    exp_rd = exp_wr; done_idx = fr_wr; wd = 0;
                end
            end else wd = 0;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // Append one frame (payload taken from pay_buf) to the expected stream
    task automatic push_exp(input logic [7:0] f, input logic [7:0] a, input int n,
                            input int nbytes, input int pl_cnt, input int lat);
        logic [15:0] c;
        logic [7:0]  b [$];
        b = {MARKER_SLAVE, f, a, 8'(n)};
        for (int i = 0; i < n; i++) b.push_back(pay_buf[i]);
        c = 16'hFFFF;
        foreach (b[i]) c = crc_model(c, b[i]);
        b.push_back(c[15:8]);
        b.push_back(c[7:0]);
        foreach (b[i]) begin
            exp_mem[exp_wr] = b[i];
            exp_wr++;
        end
        fr_bytes[fr_wr] = nbytes;
        fr_pl[fr_wr]    = pl_cnt;
        fr_lat[fr_wr]   = lat;
        fr_wr++;
    endtask

    // Load payload memory, record expectations and pulse start (call at posedge+1)
    task automatic setup(input logic [7:0] f, input logic [7:0] a, input int n,
                         input int nbytes, input int lat, input bit rnd);
        rnd_mode = rnd;
        for (int i = 0; i < n; i++) pay_mem[rd_ptr + 10'(i)] = pay_buf[i];
        push_exp(f, a, n, nbytes, n, lat);
        flag = f; addr = a; len = 8'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic launch(input logic [7:0] f, input logic [7:0] a, input int n,
                          input int nbytes, input int lat, input bit rnd,
                          input int ign_at, input int rx_at);
        int k;
`ifdef TX_ERR_REPLY_EN
        if (rx_at >= 0) begin
            setup(f, a, n, nbytes, lat, rnd);
            pay_buf[0] = 8'h20;
            push_exp(FLAG_ERR_REPLY, 8'h00, 1, 7, 0, -1);
        end else
`endif
        setup(f, a, n, nbytes, lat, rnd);
        k = 0;
        while (done_idx != fr_wr && k < 5000) begin
            if (k == ign_at) begin flag = ~f; len = 8'd7; start = 1'b1; end
            if (k == ign_at + 1) start = 1'b0;
            if (k == rx_at) begin
`ifdef TX_ERR_REPLY_EN
                rx_errs = 6'b100000; rx_frame_end = 1'b1;
`endif
            end
            if (k == rx_at + 1) begin
`ifdef TX_ERR_REPLY_EN
                rx_errs = 6'd0; rx_frame_end = 1'b0;
`endif
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] flags [4];
        int n;
        flags = '{FLAG_READ, FLAG_WRITE, FLAG_ACK, FLAG_ERR_REPLY};
        for (int i = 0; i < 9; i++) ascii[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 1024; i++) pay_mem[i] = 8'h00;

        repeat (4) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reference frame with free-flowing sink, then the 6-byte empty frame
        pay_buf[0] = 8'hA1; pay_buf[1] = 8'hA2; pay_buf[2] = 8'hA3;
        launch(8'h02, 8'h10, 3, 9, 10, 1'b0, -1, -1);
        launch(8'h02, 8'h10, 0, 6, 7, 1'b0, -1, -1);
        // Same reference frame under a 50% stalling sink
        pay_buf[0] = 8'hA1; pay_buf[1] = 8'hA2; pay_buf[2] = 8'hA3;
        launch(8'h02, 8'h10, 3, 9, -1, 1'b1, -1, -1);

        // Randomised frames, back-to-back
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) pay_buf[i] = 8'($urandom);
            launch(flags[$urandom_range(0, 3)], (t == 2) ? MARKER_MASTER : 8'($urandom),
                   n, n + 6, -1, 1'b1, -1, -1);
        end

        // Longest frame: counter must reach 255 without wrapping
        for (int i = 0; i < 255; i++) pay_buf[i] = 8'(i * 7 + 3);
        launch(FLAG_WRITE, 8'h33, 255, 261, 262, 1'b0, -1, -1);

        // A start raised mid-frame must not be queued
        for (int i = 0; i < 4; i++) pay_buf[i] = 8'($urandom);
        launch(FLAG_READ, 8'h44, 4, 10, 11, 1'b0, 3, -1);
        repeat (8) @(posedge clk);
        #1;

        // Reset while the second payload byte is on tx_data
        for (int i = 0; i < 5; i++) pay_buf[i] = 8'hC0 + 8'(i);
        setup(FLAG_WRITE, 8'h55, 5, 11, 12, 1'b0);
        repeat (5) @(posedge clk);
        #1 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) pay_buf[i] = 8'hD0 + 8'(i);
        launch(FLAG_WRITE, 8'h55, 5, 11, 12, 1'b0, -1, -1);

`ifdef TX_ERR_REPLY_EN
        // Error-reply request during a busy frame follows after its done
        pay_buf[0] = 8'hA1; pay_buf[1] = 8'hA2; pay_buf[2] = 8'hA3;
        launch(8'h02, 8'h10, 3, 9, 10, 1'b0, -1, 2);
`endif

        repeat (6) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
